// File: rtl/svm_sv_sequencer_pkg.sv
// Shared SVM widths and kernel timing for the support-vector sequencer.
// Support-vector memory words are packed as {sv, sv_class, coef_scaled, coef_sign}.
package svm_sv_sequencer_pkg;

   localparam int SVM_CLASS_WIDTH    = 2;
   localparam int SVM_COEF_WIDTH     = 15;
   localparam int SVM_DIST_WIDTH     = 16;
   localparam int SVM_KERNEL_LATENCY = 24;
   localparam int SVM_META_WIDTH     = SVM_CLASS_WIDTH + SVM_COEF_WIDTH + 1;

   // The latency counter has to hold KERNEL_LATENCY+1.
   function automatic int lat_width(input int latency);
      return $clog2(latency + 2);
   endfunction

endpackage

// File: rtl/svm_sv_sequencer.sv
// Streams every support vector past the kernel for one input vector, waits out
// the kernel pipeline, then holds the accumulated distances until they are taken.
module svm_sv_sequencer
   import svm_sv_sequencer_pkg::*;
#(
   parameter int PARAM_WIDTH    = 8,
   parameter int PARAM_COUNT    = 4,
   parameter int SV_COUNT       = 16,
   parameter int SV_INDEX_WIDTH = 4,
   parameter int KERNEL_LATENCY = SVM_KERNEL_LATENCY,
   parameter int DIST_BUS_WIDTH = 64
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic [PARAM_WIDTH*PARAM_COUNT-1:0]            in_x,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   output logic [SV_INDEX_WIDTH-1:0]                     sv_addr,
   output logic                                          sv_rd_en,
   input  logic [PARAM_WIDTH*PARAM_COUNT+SVM_META_WIDTH-1:0] sv_rd_data,
   output logic [PARAM_WIDTH*PARAM_COUNT-1:0]            k_x,
   output logic [PARAM_WIDTH*PARAM_COUNT-1:0]            k_sv,
   output logic [SVM_CLASS_WIDTH-1:0]                    k_sv_class,
   output logic [SVM_COEF_WIDTH-1:0]                     k_coef_scaled,
   output logic                                          k_coef_sign,
   output logic                                          k_new_computation,
   output logic                                          k_data_valid,
   input  logic [DIST_BUS_WIDTH-1:0]                     k_distance,
   output logic [DIST_BUS_WIDTH-1:0]                     out_distance,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [1:0]                                    dbg_state
);

   localparam int VEC_W = PARAM_WIDTH * PARAM_COUNT;
   localparam int LAT_W = lat_width(KERNEL_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } seq_state_t;

   seq_state_t                state, state_next;
   logic [SV_INDEX_WIDTH-1:0] addr_q;
   logic [LAT_W-1:0]          lat_q;
   logic [VEC_W-1:0]          x_q;
   logic                      dv_q;
   logic                      new_q;
   logic [DIST_BUS_WIDTH-1:0] dist_q;
   logic                      addr_last;

   // Handshakes: in_x moves on in_valid && in_ready, out_distance on out_valid && out_ready.
   assign in_ready  = (state == ST_IDLE);
   assign sv_rd_en  = (state == ST_FEED);
   assign out_valid = (state == ST_HOLD);
   assign sv_addr   = addr_q;
   assign addr_last = (addr_q == SV_INDEX_WIDTH'(SV_COUNT - 1));
   assign dbg_state = state;

   // Memory data arrives one cycle after the read, aligned with k_data_valid.
   assign k_x               = x_q;
   assign k_sv              = sv_rd_data[VEC_W+SVM_META_WIDTH-1 -: VEC_W];
   assign k_sv_class        = sv_rd_data[SVM_META_WIDTH-1 -: SVM_CLASS_WIDTH];
   assign k_coef_scaled     = sv_rd_data[SVM_COEF_WIDTH:1];
   assign k_coef_sign       = sv_rd_data[0];
   assign k_data_valid      = dv_q;
   assign k_new_computation = new_q;
   assign out_distance      = dist_q;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (in_valid)      state_next = ST_FEED;
         ST_FEED:  if (addr_last)     state_next = ST_DRAIN;
         ST_DRAIN: if (lat_q == '0)   state_next = ST_HOLD;
         ST_HOLD:  if (out_ready)     state_next = ST_IDLE;
         default:                     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         lat_q  <= '0;
         x_q    <= '0;
         dv_q   <= 1'b0;
         new_q  <= 1'b0;
         dist_q <= '0;
      end else begin
         state <= state_next;
         dv_q  <= sv_rd_en;
         new_q <= sv_rd_en && (addr_q == '0);
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  x_q    <= in_x;
                  addr_q <= '0;
               end
            end
            ST_FEED: begin
               // Stop at the last address instead of wrapping.
               if (addr_last) lat_q  <= LAT_W'(KERNEL_LATENCY + 1);
               else           addr_q <= addr_q + SV_INDEX_WIDTH'(1);
            end
            ST_DRAIN: begin
               if (lat_q == '0) dist_q <= k_distance;
               else             lat_q  <= lat_q - LAT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
